// File: rtl/channel_enable.sv
// Receiver-side channel enable sequencer: reads the channel word once and either
// reports a waiting sender or parks rxPid in the channel word.
module channel_enable #(
    parameter int addrBits = 16,
    parameter int dataBits = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic                finished,
    output logic [addrBits-1:0] address,
    output logic                readWriteMode,
    input  logic [dataBits-1:0] dataOut,
    output logic [dataBits-1:0] dataIn,
    input  logic [addrBits-1:0] channel,
    input  logic [addrBits-1:0] rxPid,
    output logic                rxCanReceive
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        DECIDE,
        WRITE,
        DONE
    } state_t;

    state_t              state;
    logic [dataBits-1:0] word_p0;

    function automatic logic [dataBits-1:0] zext(input logic [addrBits-1:0] v);
        return dataBits'(v);
    endfunction

    // Channel word captured from the RAM's registered output; data path only, no reset.
    always_ff @(posedge clk) begin
        if (state == WAIT) begin
            word_p0 <= dataOut;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            finished      <= 1'b0;
            rxCanReceive  <= 1'b0;
            address       <= '0;
            readWriteMode <= 1'b0;
            dataIn        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    address       <= channel;
                    readWriteMode <= 1'b0;
                    state         <= READ;
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state <= DECIDE;
                end
                DECIDE: begin
                    if (word_p0 == '0) begin
                        address       <= channel;
                        dataIn        <= zext(rxPid);
                        readWriteMode <= 1'b1;
                        rxCanReceive  <= 1'b0;
                        state         <= WRITE;
                    end else if (word_p0 == zext(rxPid)) begin
                        rxCanReceive <= 1'b0;
                        finished     <= 1'b1;
                        state        <= DONE;
                    end else begin
                        rxCanReceive <= 1'b1;
                        finished     <= 1'b1;
                        state        <= DONE;
                    end
                end
                WRITE: begin
                    // The write commits on this edge; never drive a write again.
                    readWriteMode <= 1'b0;
                    finished      <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    readWriteMode <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_enable.sv
// Directed bench for channel_enable with a behavioural single-port RAM and a
// queue of expected results consumed when finished rises.
module tb_channel_enable;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        finished;
    logic [15:0] address;
    logic        readWriteMode;
    logic [15:0] dataOut;
    logic [15:0] dataIn;
    logic [15:0] channel = '0;
    logic [15:0] rxPid = '0;
    logic        rxCanReceive;

    logic [15:0] ram [64] = '{default: 16'h0};
    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    int          wr_cnt = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        can;
        int          lat;
        logic [15:0] word;
        int          writes;
    } exp_t;
    exp_t sb[$];

    channel_enable #(.addrBits(16), .dataBits(16)) dut (
        .clk(clk),
        .reset(reset),
        .finished(finished),
        .address(address),
        .readWriteMode(readWriteMode),
        .dataOut(dataOut),
        .dataIn(dataIn),
        .channel(channel),
        .rxPid(rxPid),
        .rxCanReceive(rxCanReceive)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with registered read data; pre_en is a bench-side preset port.
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (readWriteMode) begin
            ram[address[5:0]] <= dataIn;
            wr_cnt <= wr_cnt + 1;
        end else begin
            dataOut <= ram[address[5:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_finished"}, 32'(finished), 32'h0);
        chk({tag, "_can"}, 32'(rxCanReceive), 32'h0);
        chk({tag, "_address"}, 32'(address), 32'h0);
        chk({tag, "_rw"}, 32'(readWriteMode), 32'h0);
        chk({tag, "_dataIn"}, 32'(dataIn), 32'h0);
    endtask

    // Called at a negedge: hold reset low for one edge while optionally presetting a RAM word.
    task automatic low_cycle(input logic do_pre, input logic [5:0] a, input logic [15:0] d, input string tag);
        reset    = 1'b0;
        pre_en   = do_pre;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        @(negedge clk);
        pre_en = 1'b0;
        chk_idle(tag);
    endtask

    task automatic run_op(input string tag, input logic [15:0] chan, input logic [15:0] pid,
                          input logic e_can, input int e_lat, input logic [15:0] e_word,
                          input int e_writes);
        exp_t e;
        int   edges;
        int   w0;
        logic seen;
        e.can = e_can;
        e.lat = e_lat;
        e.word = e_word;
        e.writes = e_writes;
        sb.push_back(e);
        channel = chan;
        rxPid   = pid;
        w0      = wr_cnt;
        edges   = 0;
        seen    = 1'b0;
        reset   = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (finished) seen = 1'b1;
            else chk({tag, "_can_before_finish"}, 32'(rxCanReceive), 32'h0);
        end
        e = sb.pop_front();
        chk({tag, "_timeout"}, 32'(seen), 32'h1);
        chk({tag, "_latency"}, 32'(edges), 32'(e.lat));
        chk({tag, "_can"}, 32'(rxCanReceive), 32'(e.can));
        chk({tag, "_ram"}, 32'(ram[chan[5:0]]), 32'(e.word));
        chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(e.writes));
    endtask

    initial begin
        int w0;
        @(negedge clk);
        low_cycle(1'b0, 6'd0, 16'h0, "reset0");
        low_cycle(1'b0, 6'd0, 16'h0, "reset1");

        // Empty channel: write of rxPid, finished after E4.
        run_op("empty", 16'd2, 16'd1, 1'b0, 5, 16'd1, 1);

        // Hold in DONE for 10 cycles.
        w0 = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_finished", 32'(finished), 32'h1);
            chk("hold_can", 32'(rxCanReceive), 32'h0);
            chk("hold_rw", 32'(readWriteMode), 32'h0);
        end
        chk("hold_writes", 32'(wr_cnt - w0), 32'h0);

        // Back-to-back: one low cycle with ram[2] preset to a sender.
        low_cycle(1'b1, 6'd2, 16'd3, "b2b_low");
        run_op("sender", 16'd2, 16'd1, 1'b1, 4, 16'd3, 0);

        // Idempotent enable.
        low_cycle(1'b1, 6'd5, 16'd7, "idem_low");
        run_op("idem", 16'd5, 16'd7, 1'b0, 4, 16'd7, 0);

        // Abort in WAIT on an empty channel.
        low_cycle(1'b1, 6'd2, 16'd0, "abort_low");
        w0 = wr_cnt;
        channel = 16'd2;
        rxPid   = 16'd1;
        reset   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle("abort");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_finished", 32'(finished), 32'h0);
        end
        chk("abort_ram", 32'(ram[2]), 32'h0);
        chk("abort_writes", 32'(wr_cnt - w0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_enable.md
# channel_enable

Receiver-side channel "enable" sequencer for the channel/process hardware. On start, it reads the channel word at address `channel` from the shared single-port RAM (`IceRam`) and decides whether a sender is already waiting. If none is waiting, it registers the receiving process `rxPid` in the channel word. It reports the result on `rxCanReceive` and signals completion on `finished`; the scheduler uses this to block or wake the receiver.

## Interface
- `addrBits`, default `ADDRESS_BITS` (16): RAM address width.
- `dataBits`, default `DATA_BITS` (16): RAM word width; must be ≥ addrBits.

- `clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low. Low: block held idle. High: runs one enable operation.
- `finished` out 1: high once the operation is complete; holds while `reset` stays high.
- `address` out addrBits: RAM address.
- `readWriteMode` out 1: RAM command; 0 = read, 1 = write.
- `dataOut` in dataBits: RAM read data (the RAM's output).
- `dataIn` out dataBits: RAM write data (the RAM's input).
- `channel` in addrBits: address of the channel word; stable while `reset` is high.
- `rxPid` in addrBits: receiver PID, non-zero; stable while `reset` is high.
- `rxCanReceive` out 1: valid when `finished`=1. 1 = sender waiting; 0 = receiver registered and must block.

## Operation
- **RAM contract (IceRam):**
  - Synchronous single port.
  - Write: `dataIn` is stored at `address` on the rising edge where `readWriteMode`=1.
  - Read: `dataOut` is registered and presents the word at `address` one edge after the edge where `readWriteMode`=0.
  - The RAM is not reset; its contents are initialised from its `romFile`.
- **Channel word encoding:**
  - 0 = empty.
  - Any non-zero value = PID of the process parked on the channel.
- **States:** IDLE → READ → WAIT → DECIDE → WRITE → DONE.
- **IDLE:** `reset`=0 forces IDLE. Outputs in IDLE are all 0: `finished`, `rxCanReceive`, `address`, `readWriteMode`, `dataIn`.
- **IDLE → READ:** first edge with `reset`=1. Drive `address`=`channel`, `readWriteMode`=0.
- **READ → WAIT:** the RAM registers the read.
- **WAIT → DECIDE:** `dataOut` is sampled.
- **DECIDE, word == 0:**
  - Drive `address`=`channel`, `dataIn`=`rxPid` (zero-extended), `readWriteMode`=1.
  - Go to WRITE, with `rxCanReceive`=0.
- **DECIDE, word ≠ 0 and ≠ `rxPid`:**
  - Sender present; set `rxCanReceive`=1.
  - Go to DONE with no write. The channel word is retained unchanged.
- **DECIDE, word == `rxPid`:** already enabled; set `rxCanReceive`=0 and go to DONE with no write.
- **WRITE → DONE:** the write commits on this edge; `readWriteMode` returns to 0.
- **DONE:**
  - `finished`=1 and `rxCanReceive` are held.
  - `readWriteMode`=0; the RAM is never written again.
  - Stays in DONE until `reset`=0. A new operation needs `reset` to go low for at least one edge.

## Timing
- Edge E0 is the first edge sampling `reset`=1.
- `finished` rises after edge E3 when a sender is present (or word == `rxPid`).
- `finished` rises after edge E4 when the channel was empty; the write commits at E4.
- Exactly one RAM read per operation; at most one write.
- All outputs are registered. No combinational path from inputs to outputs.
- **Reset low mid-operation:** return to IDLE on that edge with all outputs 0.
  - If `readWriteMode`=1 was already presented at that edge, the RAM write still commits.
  - No other write occurs.
- `finished` is a level, not a pulse. The consumer detects its rising edge.
- `rxCanReceive` is undefined to consumers while `finished`=0. It is driven 0 in that interval.

## Test plan
- **Empty channel:** RAM all zero, `channel`=2, `rxPid`=1, raise `reset` → `finished` rises after E4; `rxCanReceive`=0; ram[2]=1.
- **Sender present:** ram[2]=3, `channel`=2, `rxPid`=1, raise `reset` → `finished` rises after E3; `rxCanReceive`=1; ram[2] still 3; `readWriteMode` never 1.
- **Back-to-back:** run the empty case, drop `reset` for 1 cycle, preset ram[2]=3, raise `reset` again → second result `rxCanReceive`=1; all outputs 0 during the low cycle.
- **Idempotent enable:** ram[5]=7, `channel`=5, `rxPid`=7 → `rxCanReceive`=0; no write; ram[5]=7.
- **Abort:** drop `reset` in WAIT (after E1) with ram[2]=0 → IDLE next edge; ram[2] stays 0; `finished` never rises.
- **Hold:** keep `reset` high 10 cycles after DONE → `finished`=1 and `rxCanReceive` stable; no RAM writes.
